// File: rtl/bcd_pkg.sv
// bcd_pkg: shared state encoding and digit-adjust constants for the double-dabble converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  localparam logic [3:0] ADJ_THRESH = 4'd5;
  localparam logic [3:0] ADJ_OFFSET = 4'd3;
  localparam int DIGIT_W = 4;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational "if >= 5 add 3" correction for one BCD digit
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);
  assign dout = (din >= ADJ_THRESH) ? din + ADJ_OFFSET : din;
endmodule

// File: rtl/bcd_convert_ctrl.sv
// bcd_convert_ctrl: sequential double-dabble binary to packed-BCD converter, one shift per clock
module bcd_convert_ctrl
  import bcd_pkg::*;
#(
  parameter int c_BIN_WIDTH  = 8,
  parameter int c_DEC_DIGITS = 3
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_start,
  input  logic [c_BIN_WIDTH-1:0]          i_bin,
  output logic                            o_busy,
  output logic                            o_done,
  output logic [c_DEC_DIGITS*DIGIT_W-1:0] o_bcd
);
  localparam int SW = c_DEC_DIGITS * DIGIT_W;
  localparam int CW = $clog2(c_BIN_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(c_BIN_WIDTH - 1);
  state_t                 state;
  logic [c_BIN_WIDTH-1:0] r_shift;
  logic [SW-1:0]          r_scratch;
  logic [SW-1:0]          adj;
  logic [CW-1:0]          r_cnt;
  logic [SW+c_BIN_WIDTH-1:0] shifted;
  for (genvar d = 0; d < c_DEC_DIGITS; d++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (r_scratch[d*DIGIT_W +: DIGIT_W]),
      .dout (adj[d*DIGIT_W +: DIGIT_W])
    );
  end
  // adjusted scratch and operand shift together; the operand MSB falls into scratch bit 0
  assign shifted = {adj, r_shift} << 1;
  // control FSM with counter, scratch/operand registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            r_shift   <= i_bin;
            r_scratch <= '0;
            r_cnt     <= '0;
            o_busy    <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= shifted[SW+c_BIN_WIDTH-1:c_BIN_WIDTH];
          r_shift   <= shifted[c_BIN_WIDTH-1:0];
          r_cnt     <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            o_bcd  <= shifted[SW+c_BIN_WIDTH-1:c_BIN_WIDTH];
            o_done <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// tb_bcd_convert_ctrl: directed checks of the sequential BCD converter at default and wide parameters
module tb_bcd_convert_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start_w;
  logic [7:0]  bin;
  logic [9:0]  bin_w;
  logic        busy, done, busy_w, done_w;
  logic [11:0] bcd;
  logic [15:0] bcd_w;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  bcd_convert_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_bin(bin),
    .o_busy(busy), .o_done(done), .o_bcd(bcd)
  );

  bcd_convert_ctrl #(.c_BIN_WIDTH(10), .c_DEC_DIGITS(4)) dut_w (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_w), .i_bin(bin_w),
    .o_busy(busy_w), .o_done(done_w), .o_bcd(bcd_w)
  );

  function automatic logic [15:0] ref_bcd(input int n);
    ref_bcd = {4'((n / 1000) % 10), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input int v, input string nm);
    int lat;
    bit got;
    logic [15:0] r;
    r = ref_bcd(v);
    bin = 8'(v);
    start = 1'b1;
    tick();
    start = 1'b0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        lat = i;
      end
    end
    vectors++;
    if (!got || lat != 8 || bcd !== r[11:0]) begin
      miscompares++;
      $display("FAIL %s bin=%0d: done_seen=%0b latency=%0d bcd=%h, required latency=8 bcd=%h", nm, v, got, lat, bcd, r[11:0]);
    end
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    start_w = 1'b0;
    bin = '0;
    bin_w = '0;
    tick();
    tick();
    vectors++;
    if ({busy, done, bcd, busy_w, done_w, bcd_w} !== '0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b bcd=%h busy_w=%b done_w=%b bcd_w=%h, required all 0", busy, done, bcd, busy_w, done_w, bcd_w);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_timing_255();
    bin = 8'd255;
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL timing_e0: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    for (int e = 1; e <= 7; e++) begin
      tick();
      vectors++;
      if (busy !== 1'b1 || done !== 1'b0 || bcd !== 12'h000) begin
        miscompares++;
        $display("FAIL timing_e%0d: busy=%b done=%b bcd=%h, required busy=1 done=0 bcd=000", e, busy, done, bcd);
      end
    end
    tick();
    vectors++;
    if (busy !== 1'b1 || done !== 1'b1 || bcd !== 12'h255) begin
      miscompares++;
      $display("FAIL timing_e8: busy=%b done=%b bcd=%h, required busy=1 done=1 bcd=255", busy, done, bcd);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h255) begin
      miscompares++;
      $display("FAIL timing_e9: busy=%b done=%b bcd=%h, required busy=0 done=0 bcd=255", busy, done, bcd);
    end
  endtask

  task automatic test_boundaries();
    run_one(0, "bin_0");
    run_one(99, "bin_99");
    run_one(100, "bin_100");
  endtask

  task automatic test_back_to_back();
    bit idle;
    bin = 8'd42;
    start = 1'b1;
    tick();
    for (int i = 1; i <= 34; i++) begin
      tick();
      vectors++;
      if (done !== (i % 10 == 8) || (done && bcd !== 12'h042)) begin
        miscompares++;
        $display("FAIL held_start edge %0d: done=%b bcd=%h, required done=%0b bcd=042", i, done, bcd, (i % 10 == 8));
      end
    end
    start = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      tick();
      idle = !busy;
    end
    vectors++;
    if (!idle) begin
      miscompares++;
      $display("FAIL held_start_drain: busy=%b, required 0 within 20 cycles", busy);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    bin = 8'd200;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    bin = 8'd7;
    tick();
    start = 1'b0;
    bin = 8'd13;
    for (int e = 4; e <= 7; e++) tick();
    tick();
    vectors++;
    if (done !== 1'b1 || bcd !== 12'h200) begin
      miscompares++;
      $display("FAIL ignore_start_e8: done=%b bcd=%h, required done=1 bcd=200", done, bcd);
    end
    tick();
    tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_start_no_requeue: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    bin = 8'd123;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 4; e++) tick();
    rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid_immediate: busy=%b done=%b bcd=%h, required all 0", busy, done, bcd);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | done | busy;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL reset_mid_no_done: activity after abort=%b, required 0", seen);
    end
    run_one(77, "after_reset");
  endtask

  task automatic test_wide();
    int lat;
    bit got;
    bin_w = 10'd1023;
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    bin_w = 10'd0;
    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20 && !got; i++) begin
      tick();
      if (done_w) begin
        got = 1'b1;
        lat = i;
      end
    end
    vectors++;
    if (!got || lat != 10 || bcd_w !== 16'h1023) begin
      miscompares++;
      $display("FAIL wide_1023: done_seen=%0b latency=%0d bcd=%h, required latency=10 bcd=1023", got, lat, bcd_w);
    end
    tick();
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) run_one(v, "sweep");
  endtask

  initial begin
    test_reset();
    test_timing_255();
    test_boundaries();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_wide();
    test_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bcd_convert_ctrl.md
# bcd_convert_ctrl

Sequential double-dabble controller. It accepts a binary word on a start handshake and iterates one shift/adjust step per clock over a scratch BCD register. When finished it presents a registered packed-BCD result with a one-cycle done pulse. It sits between the switch-input capture logic and the seven-segment digit decoders, replacing a fully unrolled combinational converter when timing or area on wide inputs matters.

## Interface
Parameters:
- c_BIN_WIDTH, 8, binary input width in bits (≥2).
- c_DEC_DIGITS, 3, number of BCD output digits; integrator guarantees 10^c_DEC_DIGITS > 2^c_BIN_WIDTH − 1.

Ports:
- i_clk  in  1  system clock, rising-edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  request a conversion; sampled only in IDLE.
- i_bin  in  c_BIN_WIDTH  binary operand; captured on the accepting edge only.
- o_busy  out  1  high while a conversion is in progress.
- o_done  out  1  one-cycle pulse when o_bcd is updated.
- o_bcd  out  c_DEC_DIGITS*4  packed BCD result; digit 0 in bits [3:0].

## Operation
- Reset (async assert): state IDLE, o_busy=0, o_done=0, o_bcd=0, scratch, shift register and counter cleared. Deassertion takes effect synchronously on the next edge.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: i_start=1 on an edge → load r_shift=i_bin, r_scratch=0, r_cnt=0, go to SHIFT. If i_start=0, stay.
- SHIFT, one iteration per edge:
  - Each scratch digit ≥5 gets +3 (4-bit wrap is impossible by construction).
  - Then {r_scratch, r_shift} shifts left by one; the MSB of r_shift enters scratch bit 0.
  - r_cnt increments.
  - On the iteration where r_cnt reaches c_BIN_WIDTH−1, the final shifted scratch value loads o_bcd and the FSM goes to DONE.
- DONE: o_done=1 for exactly this cycle; next edge → IDLE unconditionally.
- i_start is ignored in SHIFT and DONE; there is no queuing. A start held high is re-sampled in IDLE.
- i_bin changes after acceptance have no effect on the conversion in flight.
- o_bcd holds the last result until the next DONE; it never shows intermediate scratch values.
- Reset mid-conversion aborts the conversion. No done pulse is produced and o_bcd returns to 0.
- r_cnt width is $clog2(c_BIN_WIDTH+1).

## Timing
- Accepting edge E0. Iteration edges E1..E(c_BIN_WIDTH); o_bcd and o_done update at E(c_BIN_WIDTH).
- o_busy is high from E0 through the DONE cycle and falls at E(c_BIN_WIDTH+1).
- Latency from accepting edge to result-valid is c_BIN_WIDTH cycles.
- With i_start held high, throughput is one conversion per c_BIN_WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package bcd_pkg:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - adjust threshold constant (5) and offset constant (3);
  - digit width constant (4).
- Sub-module bcd_digit_adj: a 4-bit combinational "if ≥5 add 3" cell, instantiated c_DEC_DIGITS times in a generate loop.
- The controller FSM, counter and registers stay in bcd_convert_ctrl.

## Test plan
- Defaults, i_bin=8'd255, start pulse:
  - o_busy rises at E0;
  - o_done pulses at E8 with o_bcd=12'h255;
  - o_busy falls at E9.
- i_bin=0 → o_bcd=12'h000. i_bin=99 → 12'h099. i_bin=100 → 12'h100.
- i_start held high with i_bin=8'd42: o_done pulses every 10 cycles, o_bcd=12'h042 each time.
- Start, then i_start=1 with i_bin=8'd7 at E3:
  - result at E8 is for the original operand;
  - i_bin changes during SHIFT have no effect.
- Assert i_rst_n=0 at E4 mid-conversion:
  - outputs go to 0 immediately;
  - no done pulse;
  - a new start after release converts correctly.
- c_BIN_WIDTH=10, c_DEC_DIGITS=4, i_bin=1023 → o_done at E10, o_bcd=16'h1023.
- Exhaustive sweep at defaults, 0..255: every result matches a software decimal-digit model.
